// File: rtl/branch_control_unit_pkg.sv
// Shared encodings for the branch control unit: opcodes, FSM state codes,
// ALU select codes, RF write-source codes and instruction field helpers.
package branch_control_unit_pkg;

    localparam int unsigned INST_W      = 16;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned STATE_W     = 4;
    localparam int unsigned ALU_SEL_W   = 3;
    localparam int unsigned D_ADDR_W    = 8;
    localparam int unsigned R_ADDR_W    = 4;
    localparam int unsigned JMP_TGT_W   = 12;
    localparam int unsigned BR_OFF_W    = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOOP  = 4'd0,
        OP_STORE = 4'd1,
        OP_LOAD  = 4'd2,
        OP_ADD   = 4'd3,
        OP_SUB   = 4'd4,
        OP_HALT  = 4'd5,
        OP_JMP   = 4'd6,
        OP_JZ    = 4'd7
    } opcode_e;

    typedef enum logic [STATE_W-1:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_NOOP   = 4'd3,
        ST_STORE  = 4'd4,
        ST_LOAD_A = 4'd5,
        ST_LOAD_B = 4'd6,
        ST_ADD    = 4'd7,
        ST_SUB    = 4'd8,
        ST_HALT   = 4'd9,
        ST_JUMP   = 4'd10,
        ST_BRANCH = 4'd11
    } state_e;

    typedef enum logic [ALU_SEL_W-1:0] {
        ALU_PASS_A = 3'd0,
        ALU_ADD    = 3'd1,
        ALU_SUB    = 3'd2
    } alu_sel_e;

    localparam logic RF_SRC_ALU = 1'b0;
    localparam logic RF_SRC_MEM = 1'b1;

    // Control bundle presented to the data memory, register file and ALU
    typedef struct packed {
        logic [D_ADDR_W-1:0] d_addr;
        logic                d_wr;
        logic                rf_s;
        logic [R_ADDR_W-1:0] rf_w_addr;
        logic [R_ADDR_W-1:0] rf_ra_addr;
        logic [R_ADDR_W-1:0] rf_rb_addr;
        logic                rf_w_wr;
        logic                rf_ra_rd;
        logic                rf_rb_rd;
        alu_sel_e            alu_sel;
    } ctrl_t;

    function automatic logic [OP_W-1:0] inst_op(input logic [INST_W-1:0] ir);
        return ir[15:12];
    endfunction

    function automatic logic [R_ADDR_W-1:0] field_ra(input logic [INST_W-1:0] ir);
        return ir[11:8];
    endfunction

    function automatic logic [R_ADDR_W-1:0] field_rb(input logic [INST_W-1:0] ir);
        return ir[7:4];
    endfunction

    function automatic logic [R_ADDR_W-1:0] field_rw(input logic [INST_W-1:0] ir);
        return ir[3:0];
    endfunction

    function automatic logic [D_ADDR_W-1:0] store_addr(input logic [INST_W-1:0] ir);
        return ir[7:0];
    endfunction

    function automatic logic [D_ADDR_W-1:0] load_addr(input logic [INST_W-1:0] ir);
        return ir[11:4];
    endfunction

    function automatic logic [INST_W-1:0] jump_target(input logic [INST_W-1:0] ir);
        return {{(INST_W-JMP_TGT_W){1'b0}}, ir[JMP_TGT_W-1:0]};
    endfunction

    function automatic logic [INST_W-1:0] branch_offset(input logic [INST_W-1:0] ir);
        return {{(INST_W-BR_OFF_W){ir[BR_OFF_W-1]}}, ir[BR_OFF_W-1:0]};
    endfunction

endpackage

// File: rtl/branch_control_unit_pc_register.sv
// Program counter: synchronous clear, increment, and parallel load.
// A load wins over an increment; clear wins over both.
module pc_register
    import branch_control_unit_pkg::*;
#(
    parameter int unsigned PC_W = 16
) (
    input  logic            clk_i,
    input  logic            clear_i,
    input  logic            inc_i,
    input  logic            load_i,
    input  logic [PC_W-1:0] load_val_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin : pc_next
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin : pc_reg
        if (clear_i) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/branch_control_unit.sv
// Multi-cycle control unit: fetches 16-bit instructions, sequences the data
// memory / register file / ALU, and handles JMP and zero-conditional branches.
module branch_control_unit
    import branch_control_unit_pkg::*;
#(
    parameter int unsigned PC_W        = 16,
    parameter int unsigned DATA_ADDR_W = 8,
    parameter int unsigned RF_ADDR_W   = 4
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [INST_W-1:0]      ir_inst,
    input  logic                   imem_ready,
    input  logic                   alu_zero,
    output logic [PC_W-1:0]        ir_addr,
    output logic [DATA_ADDR_W-1:0] d_addr,
    output logic                   d_wr,
    output logic                   rf_s,
    output logic [RF_ADDR_W-1:0]   rf_w_addr,
    output logic [RF_ADDR_W-1:0]   rf_ra_addr,
    output logic [RF_ADDR_W-1:0]   rf_rb_addr,
    output logic                   rf_w_wr,
    output logic                   rf_ra_rd,
    output logic                   rf_rb_rd,
    output logic [ALU_SEL_W-1:0]   alu_sel,
    output logic [INST_W-1:0]      ir_out,
    output logic [STATE_W-1:0]     state_o,
    output logic                   halted,
    output logic                   illegal
);

    state_e            state_q;
    state_e            state_d;
    logic [INST_W-1:0] ir_q;
    logic [INST_W-1:0] ir_d;
    logic              z_q;
    logic              z_d;
    logic              ill_q;
    logic              ill_d;
    logic [PC_W-1:0]   pc;
    logic              pc_inc;
    logic              pc_load;
    logic [PC_W-1:0]   pc_load_val;
    ctrl_t             ctrl;

    pc_register #(
        .PC_W (PC_W)
    ) u_pc (
        .clk_i      (clock),
        .clear_i    (clear),
        .inc_i      (pc_inc),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .pc_o       (pc)
    );

    always_ff @(posedge clock) begin : state_reg
        if (clear) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            ST_INIT:   state_d = ST_FETCH;
            ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (inst_op(ir_q))
                    OP_NOOP:  state_d = ST_NOOP;
                    OP_STORE: state_d = ST_STORE;
                    OP_LOAD:  state_d = ST_LOAD_A;
                    OP_ADD:   state_d = ST_ADD;
                    OP_SUB:   state_d = ST_SUB;
                    OP_HALT:  state_d = ST_HALT;
                    OP_JMP:   state_d = ST_JUMP;
                    OP_JZ:    state_d = ST_BRANCH;
                    default:  state_d = ST_NOOP;
                endcase
            end
            ST_LOAD_A: state_d = ST_LOAD_B;
            ST_HALT:   state_d = ST_HALT;
            ST_NOOP, ST_STORE, ST_LOAD_B, ST_ADD, ST_SUB, ST_JUMP, ST_BRANCH:
                       state_d = ST_FETCH;
            default:   state_d = ST_INIT;
        endcase
    end

    // IR / Z / illegal updates and PC control; HALT leaves all of them untouched
    always_comb begin : datapath_next
        ir_d        = ir_q;
        z_d         = z_q;
        ill_d       = ill_q;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = pc;
        case (state_q)
            ST_FETCH: begin
                if (imem_ready) begin
                    ir_d   = ir_inst;
                    pc_inc = 1'b1;
                end
            end
            ST_DECODE: begin
                if (inst_op(ir_q) > OP_W'(OP_JZ)) ill_d = 1'b1;
            end
            ST_ADD, ST_SUB: z_d = alu_zero;
            ST_JUMP: begin
                pc_load     = 1'b1;
                pc_load_val = PC_W'(jump_target(ir_q));
            end
            ST_BRANCH: begin
                if (z_q) begin
                    pc_load     = 1'b1;
                    pc_load_val = pc + PC_W'(branch_offset(ir_q));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin : datapath_regs
        if (clear) begin
            ir_q  <= '0;
            z_q   <= 1'b0;
            ill_q <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            z_q   <= z_d;
            ill_q <= ill_d;
        end
    end

    always_comb begin : output_decode
        ctrl    = '0;
        ir_addr = '0;
        case (state_q)
            ST_FETCH: ir_addr = pc;
            ST_STORE: begin
                ctrl.d_addr     = store_addr(ir_q);
                ctrl.rf_ra_addr = field_ra(ir_q);
                ctrl.rf_ra_rd   = 1'b1;
                ctrl.alu_sel    = ALU_PASS_A;
                ctrl.d_wr       = 1'b1;
            end
            ST_LOAD_A: ctrl.d_addr = load_addr(ir_q);
            ST_LOAD_B: begin
                ctrl.d_addr    = load_addr(ir_q);
                ctrl.rf_s      = RF_SRC_MEM;
                ctrl.rf_w_addr = field_rw(ir_q);
                ctrl.rf_w_wr   = 1'b1;
            end
            ST_ADD: begin
                ctrl.rf_ra_addr = field_ra(ir_q);
                ctrl.rf_rb_addr = field_rb(ir_q);
                ctrl.rf_ra_rd   = 1'b1;
                ctrl.rf_rb_rd   = 1'b1;
                ctrl.rf_w_addr  = field_rw(ir_q);
                ctrl.rf_w_wr    = 1'b1;
                ctrl.rf_s       = RF_SRC_ALU;
                ctrl.alu_sel    = ALU_ADD;
            end
            ST_SUB: begin
                ctrl.rf_ra_addr = field_ra(ir_q);
                ctrl.rf_rb_addr = field_rb(ir_q);
                ctrl.rf_ra_rd   = 1'b1;
                ctrl.rf_rb_rd   = 1'b1;
                ctrl.rf_w_addr  = field_rw(ir_q);
                ctrl.rf_w_wr    = 1'b1;
                ctrl.rf_s       = RF_SRC_ALU;
                ctrl.alu_sel    = ALU_SUB;
            end
            default: ;
        endcase
    end

    assign d_addr     = DATA_ADDR_W'(ctrl.d_addr);
    assign d_wr       = ctrl.d_wr;
    assign rf_s       = ctrl.rf_s;
    assign rf_w_addr  = RF_ADDR_W'(ctrl.rf_w_addr);
    assign rf_ra_addr = RF_ADDR_W'(ctrl.rf_ra_addr);
    assign rf_rb_addr = RF_ADDR_W'(ctrl.rf_rb_addr);
    assign rf_w_wr    = ctrl.rf_w_wr;
    assign rf_ra_rd   = ctrl.rf_ra_rd;
    assign rf_rb_rd   = ctrl.rf_rb_rd;
    assign alu_sel    = ctrl.alu_sel;
    assign ir_out     = ir_q;
    assign state_o    = state_q;
    assign halted     = (state_q == ST_HALT);
    assign illegal    = ill_q;

endmodule

// File: tb/tb_branch_control_unit.sv
// Scoreboard bench: an instruction-level model predicts every cycle's outputs
// into a queue; a negedge monitor pops and compares against the DUT.
module tb_branch_control_unit;
    import branch_control_unit_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear = 1'b1;
    logic [15:0] ir_inst = '0;
    logic        imem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic [15:0] ir_addr;
    logic [7:0]  d_addr;
    logic        d_wr, rf_s, rf_w_wr, rf_ra_rd, rf_rb_rd, halted, illegal;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_o;
    logic [2:0]  alu_sel;
    logic [15:0] ir_out;

    branch_control_unit #(.PC_W(16), .DATA_ADDR_W(8), .RF_ADDR_W(4)) dut (
        .clock(clock), .clear(clear), .ir_inst(ir_inst), .imem_ready(imem_ready),
        .alu_zero(alu_zero), .ir_addr(ir_addr), .d_addr(d_addr), .d_wr(d_wr),
        .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_ra_addr(rf_ra_addr),
        .rf_rb_addr(rf_rb_addr), .rf_w_wr(rf_w_wr), .rf_ra_rd(rf_ra_rd),
        .rf_rb_rd(rf_rb_rd), .alu_sel(alu_sel), .ir_out(ir_out), .state_o(state_o),
        .halted(halted), .illegal(illegal)
    );

    // Narrow-PC instance used for the JMP truncation case
    logic        clear8 = 1'b1;
    logic [15:0] inst8 = '0;
    logic [7:0]  ir_addr8, d_addr8;
    logic        d_wr8, rf_s8, rf_w_wr8, rf_ra_rd8, rf_rb_rd8, halted8, illegal8;
    logic [3:0]  rf_w_addr8, rf_ra_addr8, rf_rb_addr8, state8;
    logic [2:0]  alu_sel8;
    logic [15:0] ir_out8;

    branch_control_unit #(.PC_W(8), .DATA_ADDR_W(8), .RF_ADDR_W(4)) dut8 (
        .clock(clock), .clear(clear8), .ir_inst(inst8), .imem_ready(1'b1),
        .alu_zero(1'b0), .ir_addr(ir_addr8), .d_addr(d_addr8), .d_wr(d_wr8),
        .rf_s(rf_s8), .rf_w_addr(rf_w_addr8), .rf_ra_addr(rf_ra_addr8),
        .rf_rb_addr(rf_rb_addr8), .rf_w_wr(rf_w_wr8), .rf_ra_rd(rf_ra_rd8),
        .rf_rb_rd(rf_rb_rd8), .alu_sel(alu_sel8), .ir_out(ir_out8), .state_o(state8),
        .halted(halted8), .illegal(illegal8)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ia;
        logic [7:0]  da;
        logic        dwr;
        logic        rfs;
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        wwr;
        logic        rard;
        logic        rbrd;
        logic [2:0]  alu;
        logic [15:0] ir;
        logic        hlt;
        logic        ill;
    } exp_t;

    exp_t        expq[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          checking = 1'b0;
    logic [15:0] mem [0:65535];

    // Architectural model state
    logic [15:0] m_pc, m_ir;
    logic        m_z, m_ill;
    int          force_low = 0;
    bit          rand_rdy = 1'b0;
    int          zmode = 0;
    bit          clr_loadb = 1'b0;

    function automatic exp_t rec(input logic [3:0] st);
        exp_t r;
        r     = '0;
        r.st  = st;
        r.ir  = m_ir;
        r.ill = m_ill;
        r.hlt = (st == 4'd9);
        return r;
    endfunction

    task automatic cyc(input exp_t e, input logic rdy, input logic [15:0] inst,
                       input logic az, input logic clr);
        imem_ready = rdy;
        ir_inst    = inst;
        alu_zero   = az;
        clear      = clr;
        expq.push_back(e);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input exp_t e);
        cyc(e, 1'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic exec_one(output bit done);
        exp_t        e;
        logic        rdy, az;
        logic [3:0]  op;
        logic [15:0] off;
        int          lows, tries;
        done  = 1'b0;
        lows  = force_low;
        force_low = 0;
        tries = 0;
        do begin
            if (lows > 0) begin
                rdy = 1'b0;
                lows--;
            end else if (rand_rdy && tries < 20) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            tries++;
            e    = rec(4'd1);
            e.ia = m_pc;
            cyc(e, rdy, rdy ? mem[m_pc] : 16'($urandom), 1'($urandom), 1'b0);
        end while (!rdy);
        m_ir = mem[m_pc];
        m_pc = m_pc + 16'd1;
        idle(rec(4'd2));
        op = m_ir[15:12];
        if (op >= 4'd8) m_ill = 1'b1;
        case (op)
            4'd1: begin
                e = rec(4'd4); e.da = m_ir[7:0]; e.ra = m_ir[11:8];
                e.rard = 1'b1; e.dwr = 1'b1; e.alu = 3'd0;
                idle(e);
            end
            4'd2: begin
                e = rec(4'd5); e.da = m_ir[11:4];
                idle(e);
                e = rec(4'd6); e.da = m_ir[11:4]; e.rfs = 1'b1;
                e.wa = m_ir[3:0]; e.wwr = 1'b1;
                if (clr_loadb) begin
                    clr_loadb = 1'b0;
                    cyc(e, 1'b1, 16'($urandom), 1'($urandom), 1'b1);
                    m_pc = '0; m_ir = '0; m_z = 1'b0; m_ill = 1'b0;
                    idle(rec(4'd0));
                end else begin
                    idle(e);
                end
            end
            4'd3, 4'd4: begin
                e = rec((op == 4'd3) ? 4'd7 : 4'd8);
                e.ra = m_ir[11:8]; e.rb = m_ir[7:4]; e.rard = 1'b1; e.rbrd = 1'b1;
                e.wa = m_ir[3:0]; e.wwr = 1'b1; e.rfs = 1'b0;
                e.alu = (op == 4'd3) ? 3'd1 : 3'd2;
                az = (zmode == 0) ? 1'($urandom) : (zmode == 2);
                cyc(e, 1'($urandom), 16'($urandom), az, 1'b0);
                m_z = az;
            end
            4'd5: begin
                repeat (4) idle(rec(4'd9));
                n_tests++;
                if (dut.pc !== m_pc) begin
                    n_fail++;
                    $display("FAIL halt_pc: got %h expected %h", dut.pc, m_pc);
                end
                done = 1'b1;
            end
            4'd6: begin
                idle(rec(4'd10));
                m_pc = {4'd0, m_ir[11:0]};
            end
            4'd7: begin
                idle(rec(4'd11));
                off = {{8{m_ir[7]}}, m_ir[7:0]};
                if (m_z) m_pc = m_pc + off;
            end
            default: idle(rec(4'd3));
        endcase
    endtask

    task automatic run_prog(input int max_instr);
        bit done;
        checking = 1'b0;
        clear    = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        m_pc = '0; m_ir = '0; m_z = 1'b0; m_ill = 1'b0;
        checking = 1'b1;
        idle(rec(4'd0));
        for (int i = 0; i < max_instr; i++) begin
            exec_one(done);
            if (done) break;
        end
        checking = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t got, ex;
        if (checking) begin
            n_tests++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_empty: DUT state %0d with no prediction", state_o);
            end else begin
                ex       = expq.pop_front();
                got.st   = state_o;    got.ia   = ir_addr;  got.da  = d_addr;
                got.dwr  = d_wr;       got.rfs  = rf_s;     got.wa  = rf_w_addr;
                got.ra   = rf_ra_addr; got.rb   = rf_rb_addr;
                got.wwr  = rf_w_wr;    got.rard = rf_ra_rd; got.rbrd = rf_rb_rd;
                got.alu  = alu_sel;    got.ir   = ir_out;   got.hlt = halted;
                got.ill  = illegal;
                if (got !== ex) begin
                    n_fail++;
                    $display("FAIL cycle_outputs @%0t: got st=%0d ia=%h da=%h ir=%h vec=%h, expected st=%0d ia=%h da=%h ir=%h vec=%h",
                             $time, got.st, got.ia, got.da, got.ir, got, ex.st, ex.ia, ex.da, ex.ir, ex);
                end
            end
        end
    end

    task automatic clear_low_mem();
        for (int a = 0; a < 64; a++) mem[a] = 16'h0000;
    endtask

    initial begin
        logic [3:0] op;
        int         r;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;

        // JMP 0x123 on an 8-bit PC lands at 0x23
        repeat (2) @(posedge clock);
        #1;
        clear8 = 1'b0;
        inst8  = 16'h6123;
        repeat (4) @(posedge clock);
        @(negedge clock);
        n_tests++;
        if (state8 !== 4'd1) begin
            n_fail++;
            $display("FAIL jmp_pc8_state: got %0d expected 1", state8);
        end
        n_tests++;
        if (ir_addr8 !== 8'h23) begin
            n_fail++;
            $display("FAIL jmp_pc8_addr: got %h expected 23", ir_addr8);
        end
        clear8 = 1'b1;

        // LOAD / ADD / STORE / HALT sequence
        clear_low_mem();
        mem[0] = 16'h2101; mem[1] = 16'h3112; mem[2] = 16'h1220; mem[3] = 16'h5000;
        rand_rdy = 1'b0; zmode = 0;
        run_prog(10);

        // JZ -2 from address 5, taken and not taken
        clear_low_mem();
        mem[0] = 16'h3000; mem[1] = 16'h6005; mem[5] = 16'h70FE;
        mem[4] = 16'h5000; mem[6] = 16'h5000;
        zmode = 2; run_prog(10);
        zmode = 1; run_prog(10);

        // Branch wrapping through the top of the address space
        clear_low_mem();
        mem[0] = 16'h3000; mem[1] = 16'h70FC; mem[16'hFFFE] = 16'h7001;
        zmode = 2; run_prog(5);
        mem[16'hFFFE] = 16'h0000;

        // Stalled fetch, illegal opcode, clear during LOAD_B
        clear_low_mem();
        mem[0] = 16'hA123; mem[1] = 16'h2345; mem[2] = 16'h5000;
        zmode = 0; force_low = 3; clr_loadb = 1'b1;
        run_prog(8);

        // Random programs with random memory stalls and ALU zero flags
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < 64; a++) begin
                r  = $urandom_range(0, 15);
                op = (r < 14) ? 4'(r % 8) : 4'(8 + $urandom_range(0, 7));
                if (op == 4'd5 && $urandom_range(0, 3) != 0) op = 4'd3;
                if (op == 4'd6) mem[a] = {op, 12'($urandom_range(0, 63))};
                else            mem[a] = {op, 12'($urandom)};
            end
            rand_rdy = 1'b1; zmode = 0;
            run_prog(40);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
